// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//   Scan scheduler for a 6-digit common-anode 7-segment display. Six BCD
//   digits are time-multiplexed onto one shared segment bus. A blanking gap
//   separates digit slots to suppress ghosting. New display contents are
//   accepted only at frame boundaries, so a frame never tears.
//
// Parameters
//   TICK_CYC   clk cycles each digit is driven (>= 1)
//   BLANK_CYC  clk cycles all digits are dark between slots (>= 1)
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   boot_flag   1 = display scanning, 0 = display off
//   disp_data   six BCD digits, [3:0] = digit0 (rightmost) .. [23:20] = digit5
//   disp_dp     decimal point per digit, 1 = lit
//   disp_mask   digit enable, 1 = shown, 0 = kept dark
//   load_valid  disp_* valid this cycle
//   load_ready  a load can be accepted this cycle
//   sel         digit select, active-low, bit i drives digit i
//   seg         segments, active-low, {dp,g,f,e,d,c,b,a}
//   frame_done  one-cycle pulse in the first blank after digit5's slot
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
   parameter int unsigned TICK_CYC  = 1000,
   parameter int unsigned BLANK_CYC = 50
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        boot_flag,
   input  logic [23:0] disp_data,
   input  logic [5:0]  disp_dp,
   input  logic [5:0]  disp_mask,
   input  logic        load_valid,
   output logic        load_ready,
   output logic [5:0]  sel,
   output logic [7:0]  seg,
   output logic        frame_done
);

   localparam int unsigned CNT_MAX = (TICK_CYC > BLANK_CYC) ? TICK_CYC : BLANK_CYC;
   localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_CYC - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [2:0]    LAST_IDX   = 3'd5;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      SHOW
   } state_t;

   state_t        state, state_n;
   logic [2:0]    idx, idx_n;
   logic [CW-1:0] cnt, cnt_n;

   logic [23:0]   data_q, data_n;
   logic [5:0]    dp_q, dp_n;
   logic [5:0]    mask_q, mask_n;

   logic [5:0]    sel_n;
   logic [7:0]    seg_n;
   logic          load_ready_n;
   logic          frame_done_n;
   logic          take;
   logic [5:0]    onehot;

   // BCD to active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash
   function automatic logic [6:0] decode(input logic [3:0] bcd);
      logic [6:0] r;
      case (bcd)
         4'd0:    r = 7'h40;
         4'd1:    r = 7'h79;
         4'd2:    r = 7'h24;
         4'd3:    r = 7'h30;
         4'd4:    r = 7'h19;
         4'd5:    r = 7'h12;
         4'd6:    r = 7'h02;
         4'd7:    r = 7'h78;
         4'd8:    r = 7'h00;
         4'd9:    r = 7'h10;
         default: r = 7'h3F;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] pick_digit(input logic [23:0] d, input logic [2:0] i);
      logic [3:0] r;
      case (i)
         3'd0:    r = d[3:0];
         3'd1:    r = d[7:4];
         3'd2:    r = d[11:8];
         3'd3:    r = d[15:12];
         3'd4:    r = d[19:16];
         3'd5:    r = d[23:20];
         default: r = 4'h0;
      endcase
      return r;
   endfunction

   always_comb begin
      state_n      = state;
      idx_n        = idx;
      cnt_n        = cnt;
      frame_done_n = 1'b0;

      // A transfer completes even when boot_flag drops in the same cycle
      take   = load_valid & load_ready;
      data_n = take ? disp_data : data_q;
      dp_n   = take ? disp_dp   : dp_q;
      mask_n = take ? disp_mask : mask_q;

      if (!boot_flag) begin
         state_n = IDLE;
         idx_n   = '0;
         cnt_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_n = BLANK;
               idx_n   = '0;
               cnt_n   = '0;
            end
            BLANK: begin
               if (cnt == BLANK_LAST) begin
                  state_n = SHOW;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            SHOW: begin
               if (cnt == TICK_LAST) begin
                  state_n = BLANK;
                  cnt_n   = '0;
                  if (idx == LAST_IDX) begin
                     idx_n        = '0;
                     frame_done_n = 1'b1;
                  end else begin
                     idx_n = idx + 3'd1;
                  end
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            default: begin
               state_n = IDLE;
               idx_n   = '0;
               cnt_n   = '0;
            end
         endcase
      end

      // Outputs are registered, so they are derived from the next state
      onehot       = 6'b1 << idx_n;
      sel_n        = '1;
      seg_n        = '1;
      load_ready_n = (state_n == IDLE) ||
                     ((state_n == SHOW) && (idx_n == LAST_IDX) && (cnt_n == TICK_LAST));
      if (state_n == SHOW) begin
         sel_n = mask_n[idx_n] ? ~onehot : 6'h3F;
         seg_n = {~dp_n[idx_n], decode(pick_digit(data_n, idx_n))};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         cnt        <= '0;
         data_q     <= '0;
         dp_q       <= '0;
         mask_q     <= '0;
         sel        <= '1;
         seg        <= '1;
         load_ready <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         cnt        <= cnt_n;
         data_q     <= data_n;
         dp_q       <= dp_n;
         mask_q     <= mask_n;
         sel        <= sel_n;
         seg        <= seg_n;
         load_ready <= load_ready_n;
         frame_done <= frame_done_n;
      end
   end

endmodule
